// File: rtl/layer_result_buffer_pkg.sv
// layer_result_buffer_pkg: default geometry and fill/drain state encoding
package layer_result_buffer_pkg;
  localparam int DEF_ADDRESS   = 4;
  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_DATANUM   = 15;
  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;
endpackage

// File: rtl/layer_result_buffer_ring_pointer.sv
// ring_pointer: enable-driven one-hot rotating register with wrap pulse and binary address
module ring_pointer #(
  parameter int N  = 15,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          wrap,
  output logic [AW-1:0] addr
);
  logic [N-1:0] ptr_q, ptr_d;
  always_comb begin
    ptr_d = en ? {ptr_q[N-2:0], ptr_q[N-1]} : ptr_q;
    addr  = '0;
    for (int i = 0; i < N; i++) addr = ptr_q[i] ? (addr | AW'(i)) : addr;
  end
  assign wrap = en & ptr_q[N-1];
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= N'(1);
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/layer_result_buffer.sv
// layer_result_buffer: fill-then-drain result store handing one layer's outputs to the next in write order
module layer_result_buffer
  import layer_result_buffer_pkg::*;
#(
  parameter int ADDRESS   = DEF_ADDRESS,
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int DATANUM   = DEF_DATANUM
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 WrEn,
  input  logic [DATAWIDTH-1:0] WrData,
  input  logic                 RdEn,
  output logic [DATAWIDTH-1:0] RdData,
  output logic                 RdValid,
  output logic                 Full,
  output logic                 Empty,
  output logic [ADDRESS-1:0]   WrAddr,
  output logic [ADDRESS-1:0]   RdAddr,
  output logic                 Overflow,
  output logic                 Underflow
);
  state_t state_q, state_d;
  logic [DATAWIDTH-1:0] mem [DATANUM];
  logic [DATAWIDTH-1:0] rd_data_q, rd_data_d;
  logic rd_valid_q, rd_valid_d, full_q, full_d, empty_q, empty_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic wr_ok, rd_ok, wr_wrap, rd_wrap;
  assign wr_ok = WrEn & (state_q == FILL);
  assign rd_ok = RdEn & (state_q == DRAIN);
  ring_pointer #(.N(DATANUM), .AW(ADDRESS)) u_wr_ptr (
    .clk(clk), .rst_n(rst_n), .en(wr_ok), .wrap(wr_wrap), .addr(WrAddr)
  );
  ring_pointer #(.N(DATANUM), .AW(ADDRESS)) u_rd_ptr (
    .clk(clk), .rst_n(rst_n), .en(rd_ok), .wrap(rd_wrap), .addr(RdAddr)
  );
  // illegal-state accesses are dropped but remembered in the sticky flags
  always_comb begin
    state_d    = wr_wrap ? DRAIN : (rd_wrap ? FILL : state_q);
    full_d     = wr_wrap ? 1'b1 : (rd_wrap ? 1'b0 : full_q);
    empty_d    = wr_ok ? 1'b0 : (rd_wrap ? 1'b1 : empty_q);
    rd_data_d  = rd_ok ? mem[RdAddr] : rd_data_q;
    rd_valid_d = rd_ok;
    ovf_d      = ovf_q | (WrEn & (state_q != FILL));
    unf_d      = unf_q | (RdEn & (state_q != DRAIN));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FILL;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) mem[WrAddr] <= WrData;
  end
  assign RdData    = rd_data_q;
  assign RdValid   = rd_valid_q;
  assign Full      = full_q;
  assign Empty     = empty_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;
endmodule

// File: tb/tb_layer_result_buffer.sv
// tb_layer_result_buffer: scenario tasks with a write-order scoreboard for layer_result_buffer
module tb_layer_result_buffer;
  logic clk = 1'b0, rst_n = 1'b0, WrEn = 1'b0, RdEn = 1'b0;
  logic [7:0] WrData = 8'h00;
  logic [7:0] RdData;
  logic RdValid, Full, Empty, Overflow, Underflow;
  logic [3:0] WrAddr, RdAddr;
  int tests = 0, fails = 0, wptr = 0;
  logic [7:0] wq[$], exp_q[$];

  layer_result_buffer dut (
    .clk(clk), .rst_n(rst_n), .WrEn(WrEn), .WrData(WrData), .RdEn(RdEn),
    .RdData(RdData), .RdValid(RdValid), .Full(Full), .Empty(Empty),
    .WrAddr(WrAddr), .RdAddr(RdAddr), .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task reset_dut;
    rst_n = 1'b0; WrEn = 1'b0; RdEn = 1'b0;
    tick();
    rst_n = 1'b1;
    wq.delete(); exp_q.delete(); wptr = 0;
  endtask

  task fill(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      WrEn = 1'b1; WrData = base + 8'(i);
      tick();
      wq.push_back(WrData);
      wptr = (wptr + 1) % 15;
      tests++;
      if (Full !== (wptr == 0) || Empty !== 1'b0 || WrAddr !== 4'(wptr)) begin
        fails++;
        $display("FAIL fill[%0d]: got Full=%b Empty=%b WrAddr=%0d, want Full=%b Empty=0 WrAddr=%0d",
                 i, Full, Empty, WrAddr, wptr == 0, wptr);
      end
    end
    WrEn = 1'b0;
  endtask

  task drain(input bit gaps, input bit b2b);
    logic [7:0] e;
    for (int i = 0; i < 15; i++) begin
      RdEn = 1'b1;
      exp_q.push_back(wq.pop_front());
      tick();
      e = exp_q.pop_front();
      tests++;
      if (RdValid !== 1'b1 || RdData !== e || RdAddr !== 4'((i + 1) % 15) || Full !== (i < 14)) begin
        fails++;
        $display("FAIL drain[%0d]: got RdValid=%b RdData=%h RdAddr=%0d Full=%b, want 1 %h %0d %b",
                 i, RdValid, RdData, RdAddr, Full, e, (i + 1) % 15, i < 14);
      end
      if (gaps && i < 14) begin
        RdEn = 1'b0;
        tick();
        tests++;
        if (RdValid !== 1'b0 || RdData !== e) begin
          fails++;
          $display("FAIL gap[%0d]: got RdValid=%b RdData=%h, want 0 %h", i, RdValid, RdData, e);
        end
      end
    end
    RdEn = 1'b0;
    tests++;
    if (Full !== 1'b0 || Empty !== 1'b1 || RdAddr !== 4'd0) begin
      fails++;
      $display("FAIL drain_end: got Full=%b Empty=%b RdAddr=%0d, want 0 1 0", Full, Empty, RdAddr);
    end
    if (b2b) begin
      WrEn = 1'b1; WrData = 8'h77;
      tick();
      WrEn = 1'b0;
      wq.push_back(8'h77);
      wptr = 1;
      tests++;
      if (WrAddr !== 4'd1 || Overflow !== 1'b0 || Empty !== 1'b0 || RdValid !== 1'b0) begin
        fails++;
        $display("FAIL b2b_write: got WrAddr=%0d Overflow=%b Empty=%b RdValid=%b, want 1 0 0 0",
                 WrAddr, Overflow, Empty, RdValid);
      end
    end else begin
      tick();
      tests++;
      if (RdValid !== 1'b0) begin
        fails++;
        $display("FAIL drain_idle: got RdValid=%b, want 0", RdValid);
      end
    end
  endtask

  task test_reset;
    reset_dut();
    tests++;
    if (RdValid !== 1'b0 || Full !== 1'b0 || Empty !== 1'b1 || WrAddr !== 4'd0 || RdAddr !== 4'd0 ||
        Overflow !== 1'b0 || Underflow !== 1'b0 || RdData !== 8'h00) begin
      fails++;
      $display("FAIL reset: got V=%b F=%b E=%b WA=%0d RA=%0d O=%b U=%b D=%h, want 0 0 1 0 0 0 0 00",
               RdValid, Full, Empty, WrAddr, RdAddr, Overflow, Underflow, RdData);
    end
  endtask

  task test_basic;
    reset_dut();
    fill(8'h10, 15);
    drain(1'b0, 1'b0);
    tests++;
    if (Overflow !== 1'b0 || Underflow !== 1'b0) begin
      fails++;
      $display("FAIL basic_flags: got O=%b U=%b, want 0 0", Overflow, Underflow);
    end
  endtask

  task test_underflow;
    reset_dut();
    RdEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (RdValid !== 1'b0 || Underflow !== 1'b1 || RdAddr !== 4'd0 || Empty !== 1'b1) begin
        fails++;
        $display("FAIL underflow[%0d]: got V=%b U=%b RA=%0d E=%b, want 0 1 0 1", i, RdValid, Underflow, RdAddr, Empty);
      end
    end
    RdEn = 1'b0;
  endtask

  task test_overflow;
    reset_dut();
    fill(8'hA0, 15);
    WrEn = 1'b1; WrData = 8'hFF;
    tick();
    WrEn = 1'b0;
    tests++;
    if (Overflow !== 1'b1 || WrAddr !== 4'd0 || Full !== 1'b1 || Underflow !== 1'b0) begin
      fails++;
      $display("FAIL overflow: got O=%b WA=%0d F=%b U=%b, want 1 0 1 0", Overflow, WrAddr, Full, Underflow);
    end
    drain(1'b0, 1'b0);
    tests++;
    if (Overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_sticky: got O=%b, want 1", Overflow);
    end
  endtask

  task test_gapped;
    reset_dut();
    fill(8'h30, 15);
    drain(1'b1, 1'b0);
  endtask

  task test_reset_mid;
    reset_dut();
    fill(8'h60, 7);
    reset_dut();
    tests++;
    if (WrAddr !== 4'd0 || Empty !== 1'b1 || Full !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got WA=%0d E=%b F=%b, want 0 1 0", WrAddr, Empty, Full);
    end
    fill(8'h01, 15);
    drain(1'b0, 1'b0);
  endtask

  task test_back_to_back;
    reset_dut();
    fill(8'h50, 15);
    drain(1'b0, 1'b1);
    fill(8'h81, 14);
    drain(1'b0, 1'b0);
    tests++;
    if (Overflow !== 1'b0 || Underflow !== 1'b0) begin
      fails++;
      $display("FAIL b2b_flags: got O=%b U=%b, want 0 0", Overflow, Underflow);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_overflow();
    test_gapped();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
